// File: rtl/mu0_control.sv
// mu0_control: MU0 fetch/execute control unit.
// Decodes the opcode F and the accumulator flags N/Z into the register
// enables, datapath selects, ALU function and memory request.
// Optional build macro: MU0_WAIT_EN. When defined, any cycle that requests
// memory holds its state while Ready=0, with the register enables suppressed.
`timescale 1ns/1ps
module mu0_control (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] F,
  input  logic       N,
  input  logic       Z,
  input  logic       Ready,
  output logic       Addr_sel,
  output logic       X_sel,
  output logic       Y_sel,
  output logic [1:0] M,
  output logic       PC_En,
  output logic       IR_En,
  output logic       Acc_En,
  output logic       MEM_rq,
  output logic       RnW,
  output logic       Halted
);

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    EXECUTE = 2'b01,
    HALT    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [1:0] ALU_PASS_Y = 2'b00;
  localparam logic [1:0] ALU_ADD    = 2'b01;
  localparam logic [1:0] ALU_INC_X  = 2'b10;
  localparam logic [1:0] ALU_SUB    = 2'b11;

  state_t state;
  state_t state_nxt;
  logic   stall;

`ifndef MU0_WAIT_EN
  // Ready only matters for the wait-state build.
  logic unused_ready;
  assign unused_ready = Ready;
`endif

  // Output and next-state decode from the current state, opcode and flags.
  always_comb begin
    // NOTE: every output gets a default first so no decode path can infer a latch.
    Addr_sel  = 1'b0;
    X_sel     = 1'b0;
    Y_sel     = 1'b0;
    M         = ALU_PASS_Y;
    PC_En     = 1'b0;
    IR_En     = 1'b0;
    Acc_En    = 1'b0;
    MEM_rq    = 1'b0;
    RnW       = 1'b1;
    Halted    = 1'b0;
    state_nxt = FETCH;

    case (state)
      FETCH: begin
        // Read the instruction at PC into IR while PC advances by one.
        MEM_rq    = 1'b1;
        IR_En     = 1'b1;
        X_sel     = 1'b1;
        M         = ALU_INC_X;
        PC_En     = 1'b1;
        state_nxt = EXECUTE;
      end
      EXECUTE: begin
        Addr_sel  = 1'b1;
        state_nxt = FETCH;
        case (F)
          OP_LDA: begin
            MEM_rq = 1'b1;
            Acc_En = 1'b1;
          end
          OP_STA: begin
            MEM_rq = 1'b1;
            RnW    = 1'b0;
          end
          OP_ADD: begin
            MEM_rq = 1'b1;
            M      = ALU_ADD;
            Acc_En = 1'b1;
          end
          OP_SUB: begin
            MEM_rq = 1'b1;
            M      = ALU_SUB;
            Acc_En = 1'b1;
          end
          OP_JMP: begin
            Y_sel = 1'b1;
            PC_En = 1'b1;
          end
          OP_JGE: begin
            Y_sel = 1'b1;
            PC_En = ~N;
          end
          OP_JNE: begin
            Y_sel = 1'b1;
            PC_En = ~Z;
          end
          OP_STP: state_nxt = HALT;
          default: ;  // 8-F: no operation
        endcase
      end
      HALT: begin
        Halted    = 1'b1;
        state_nxt = HALT;
      end
      default: state_nxt = FETCH;  // illegal encoding recovers to FETCH
    endcase

`ifdef MU0_WAIT_EN
    stall = MEM_rq & ~Ready;
`else
    stall = 1'b0;
`endif

    // A stalled memory cycle keeps its address/selects but commits nothing.
    if (stall) begin
      PC_En     = 1'b0;
      IR_En     = 1'b0;
      Acc_En    = 1'b0;
      state_nxt = state;
    end

    // Reset suppresses every side effect, including any in-flight instruction.
    if (!Reset) begin
      PC_En  = 1'b0;
      IR_En  = 1'b0;
      Acc_En = 1'b0;
      MEM_rq = 1'b0;
      Halted = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (!Reset) state <= FETCH;
    else        state <= state_nxt;
  end

endmodule

// File: tb/tb_mu0_control.sv
// tb_mu0_control: self-checking bench for mu0_control.
// Directed table of one-cycle vectors, hand sequences for halt, mid-instruction
// reset and wait states, then randomized cycles against a behavioural model.
`timescale 1ns/1ps
module tb_mu0_control;

  logic       Clk;
  logic       Reset;
  logic [3:0] F;
  logic       N;
  logic       Z;
  logic       Ready;
  logic       Addr_sel;
  logic       X_sel;
  logic       Y_sel;
  logic [1:0] M;
  logic       PC_En;
  logic       IR_En;
  logic       Acc_En;
  logic       MEM_rq;
  logic       RnW;
  logic       Halted;

  mu0_control dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .F        (F),
    .N        (N),
    .Z        (Z),
    .Ready    (Ready),
    .Addr_sel (Addr_sel),
    .X_sel    (X_sel),
    .Y_sel    (Y_sel),
    .M        (M),
    .PC_En    (PC_En),
    .IR_En    (IR_En),
    .Acc_En   (Acc_En),
    .MEM_rq   (MEM_rq),
    .RnW      (RnW),
    .Halted   (Halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

`ifdef MU0_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  // Output bundle: {Addr_sel, X_sel, Y_sel, M[1:0], PC_En, IR_En, Acc_En, MEM_rq, RnW, Halted}
  logic [10:0] outs;
  assign outs = {Addr_sel, X_sel, Y_sel, M, PC_En, IR_En, Acc_En, MEM_rq, RnW, Halted};

  localparam logic [10:0] FETCH_O   = 11'b0_1_0_10_1_1_0_1_1_0;
  localparam logic [10:0] RSTF_O    = 11'b0_1_0_10_0_0_0_0_1_0;
  localparam logic [10:0] LDA_O     = 11'b1_0_0_00_0_0_1_1_1_0;
  localparam logic [10:0] ADD_O     = 11'b1_0_0_01_0_0_1_1_1_0;
  localparam logic [10:0] SUB_O     = 11'b1_0_0_11_0_0_1_1_1_0;
  localparam logic [10:0] STA_O     = 11'b1_0_0_00_0_0_0_1_0_0;
  localparam logic [10:0] JNT_O     = 11'b1_0_1_00_0_0_0_0_1_0;
  localparam logic [10:0] JT_O      = 11'b1_0_1_00_1_0_0_0_1_0;
  localparam logic [10:0] NOP_O     = 11'b1_0_0_00_0_0_0_0_1_0;
  localparam logic [10:0] ADDRST_O  = 11'b1_0_0_01_0_0_0_0_1_0;
  localparam logic [10:0] HALT_O    = 11'b0_0_0_00_0_0_0_0_1_1;
  localparam logic [10:0] HALTRST_O = 11'b0_0_0_00_0_0_0_0_1_0;
  localparam logic [10:0] FSTALL_O  = 11'b0_1_0_10_0_0_0_1_1_0;
  localparam logic [10:0] LSTALL_O  = 11'b1_0_0_00_0_0_0_1_1_0;

  typedef struct {
    logic        rst;
    logic [3:0]  f;
    logic        n;
    logic        z;
    logic        rdy;
    logic [10:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  localparam int P_FETCH = 0;
  localparam int P_EXEC  = 1;
  localparam int P_HALT  = 2;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (Addr X Y M PC IR Acc MEM RnW Halt)", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge.
  task automatic drive(input logic rst, input logic [3:0] f, input logic n, input logic z,
                       input logic rdy);
    @(negedge Clk);
    Reset = rst;
    F     = f;
    N     = n;
    Z     = z;
    Ready = rdy;
  endtask

  // Drive, let the decode settle, and compare before the next rising edge.
  task automatic apply(input logic rst, input logic [3:0] f, input logic n, input logic z,
                       input logic rdy, input logic [10:0] exp, input string name);
    drive(rst, f, n, z, rdy);
    #1;
    check(name, outs, exp);
  endtask

  // Behavioural model: what each instruction class does in each phase.
  function automatic logic [10:0] model(input int phase, input logic rst, input logic [3:0] f,
                                        input logic n, input logic z, input logic rdy,
                                        output int nxt);
    logic a, x, y, pc, ir, acc, mem, rw, h;
    logic [1:0] m;
    bit is_mem, is_jump, taken;
    a = 1'b0; x = 1'b0; y = 1'b0; m = 2'd0; pc = 1'b0; ir = 1'b0;
    acc = 1'b0; mem = 1'b0; rw = 1'b1; h = 1'b0;
    nxt = phase;
    if (phase == P_FETCH) begin
      x = 1'b1; m = 2'd2; pc = 1'b1; ir = 1'b1; mem = 1'b1;
      nxt = P_EXEC;
    end else if (phase == P_EXEC) begin
      is_mem  = (f < 4'd4);
      is_jump = (f >= 4'd4) && (f <= 4'd6);
      taken   = (f == 4'd4) || (f == 4'd5 && !n) || (f == 4'd6 && !z);
      a   = 1'b1;
      mem = is_mem;
      rw  = (f != 4'd1);
      y   = is_jump;
      pc  = is_jump && taken;
      acc = is_mem && (f != 4'd1);
      m   = (f == 4'd2) ? 2'd1 : (f == 4'd3) ? 2'd3 : 2'd0;
      nxt = (f == 4'd7) ? P_HALT : P_FETCH;
    end else begin
      h = 1'b1;
    end
    if (WAIT_EN && mem && !rdy) begin
      pc = 1'b0; ir = 1'b0; acc = 1'b0;
      nxt = phase;
    end
    if (!rst) begin
      pc = 1'b0; ir = 1'b0; acc = 1'b0; mem = 1'b0; h = 1'b0;
      nxt = P_FETCH;
    end
    return {a, x, y, m, pc, ir, acc, mem, rw, h};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int phase;
    int nxt;
    logic        r_rst, r_n, r_z, r_rdy;
    logic [3:0]  r_f;
    logic [10:0] exp;

    Reset = 1'b0; F = 4'h0; N = 1'b0; Z = 1'b0; Ready = 1'b1;

    // Directed one-cycle vectors; each row is applied then the clock advances.
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b1, RSTF_O,  "reset_held"});
    vecs.push_back('{1'b1, 4'h0, 1'b1, 1'b1, 1'b1, FETCH_O, "fetch_after_reset"});
    vecs.push_back('{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, LDA_O,   "exec_lda"});
    vecs.push_back('{1'b1, 4'h5, 1'b1, 1'b1, 1'b1, FETCH_O, "fetch_flags_ignored"});
    vecs.push_back('{1'b1, 4'h2, 1'b0, 1'b0, 1'b1, ADD_O,   "exec_add"});
    vecs.push_back('{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, FETCH_O, "fetch"});
    vecs.push_back('{1'b1, 4'h3, 1'b1, 1'b0, 1'b1, SUB_O,   "exec_sub"});
    vecs.push_back('{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, FETCH_O, "fetch"});
    vecs.push_back('{1'b1, 4'h1, 1'b0, 1'b0, 1'b1, STA_O,   "exec_sta"});
    vecs.push_back('{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, FETCH_O, "fetch"});
    vecs.push_back('{1'b1, 4'h5, 1'b1, 1'b0, 1'b1, JNT_O,   "jge_n1_not_taken"});
    vecs.push_back('{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, FETCH_O, "fetch"});
    vecs.push_back('{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, JT_O,    "jge_n0_taken"});
    vecs.push_back('{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, FETCH_O, "fetch"});
    vecs.push_back('{1'b1, 4'h6, 1'b0, 1'b1, 1'b1, JNT_O,   "jne_z1_not_taken"});
    vecs.push_back('{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, FETCH_O, "fetch"});
    vecs.push_back('{1'b1, 4'h6, 1'b1, 1'b0, 1'b1, JT_O,    "jne_z0_taken"});
    vecs.push_back('{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, FETCH_O, "fetch"});
    vecs.push_back('{1'b1, 4'h4, 1'b1, 1'b1, 1'b1, JT_O,    "jmp_always"});
    vecs.push_back('{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, FETCH_O, "fetch"});
    vecs.push_back('{1'b1, 4'hC, 1'b0, 1'b0, 1'b1, NOP_O,   "exec_nop_c"});
    vecs.push_back('{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, FETCH_O, "fetch_after_nop"});
    vecs.push_back('{1'b0, 4'h2, 1'b0, 1'b0, 1'b1, ADDRST_O,"reset_mid_add"});
    vecs.push_back('{1'b1, 4'h2, 1'b0, 1'b0, 1'b1, FETCH_O, "fetch_after_mid_reset"});
    vecs.push_back('{1'b1, 4'h7, 1'b0, 1'b0, 1'b1, NOP_O,   "exec_stp"});

    // One unchecked reset edge so the state is known before the table starts.
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    foreach (vecs[i]) apply(vecs[i].rst, vecs[i].f, vecs[i].n, vecs[i].z, vecs[i].rdy,
                            vecs[i].exp, vecs[i].name);

    // Halted for ten cycles regardless of opcode and flags.
    for (int i = 0; i < 10; i++)
      apply(1'b1, 4'(i), i[0], i[1], 1'b1, HALT_O, "halt_hold");
    apply(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, HALTRST_O, "reset_in_halt");
    apply(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, FETCH_O,   "fetch_after_halt");

`ifdef MU0_WAIT_EN
    // Stall in FETCH, then in EXECUTE of LDA; a jump ignores Ready.
    apply(1'b0, 4'hC, 1'b0, 1'b0, 1'b1, NOP_O, "reset_before_wait");
    for (int i = 0; i < 3; i++)
      apply(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, FSTALL_O, "fetch_stall");
    apply(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, FETCH_O, "fetch_ready");
    for (int i = 0; i < 3; i++)
      apply(1'b1, 4'h0, 1'b0, 1'b0, 1'b0, LSTALL_O, "lda_stall");
    apply(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, LDA_O,   "lda_ready");
    apply(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, FETCH_O, "fetch_after_lda");
    apply(1'b1, 4'h4, 1'b0, 1'b0, 1'b0, JT_O,    "jmp_ignores_ready");
    apply(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, FETCH_O, "fetch_after_jmp");
`endif

    // Randomized cycles against the behavioural model.
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    phase = P_FETCH;
    for (int i = 0; i < 1500; i++) begin
      r_rst = ($urandom_range(0, 9) != 0);
      r_f   = 4'($urandom_range(0, 15));
      r_n   = 1'($urandom_range(0, 1));
      r_z   = 1'($urandom_range(0, 1));
      r_rdy = ($urandom_range(0, 3) != 0);
      exp   = model(phase, r_rst, r_f, r_n, r_z, r_rdy, nxt);
      apply(r_rst, r_f, r_n, r_z, r_rdy, exp, "random");
      phase = nxt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mu0_control.md
# mu0_control

MU0 control unit: a fetch/execute state machine that decodes the 4-bit opcode from the instruction register and drives the enables of the 12-bit PC, IR and accumulator registers, the datapath multiplexer selects, the ALU function and the memory request. It sits directly upstream of the mu0_reg12 instances and supplies their En inputs. It also consumes the N/Z flags from the accumulator and the opcode field F = IR[15:12].

## Interface
- Parameters: none. Widths are fixed by the MU0 16-bit ISA.
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising Clk).
- F  in  4  opcode, IR[15:12].
- N  in  1  accumulator negative flag (Acc[15]).
- Z  in  1  accumulator zero flag (Acc == 0).
- Ready  in  1  memory ready. Used only when MU0_WAIT_EN is defined; ignored otherwise.
- Addr_sel  out  1  address mux: 0 = PC, 1 = IR[11:0].
- X_sel  out  1  ALU X mux: 0 = Acc, 1 = PC.
- Y_sel  out  1  ALU Y mux: 0 = memory data, 1 = IR[11:0] zero-extended.
- M  out  2  ALU function: 00 pass Y, 01 X+Y, 10 X+1, 11 X−Y.
- PC_En  out  1  PC register enable.
- IR_En  out  1  IR register enable.
- Acc_En  out  1  accumulator enable.
- MEM_rq  out  1  memory request.
- RnW  out  1  1 = read, 0 = write.
- Halted  out  1  high in HALT state.

## Operation
- State register, 2 bits: FETCH = 00, EXECUTE = 01, HALT = 10. Code 11 is illegal and returns to FETCH on the next edge.
- Outputs are a combinational decode of state and F (Mealy on F, N, Z).
- **FETCH:** Addr_sel=0, MEM_rq=1, RnW=1, IR_En=1, X_sel=1, M=10, PC_En=1. Next state is EXECUTE.
- **EXECUTE:** Addr_sel=1. Decode by F:
  - 0 LDA: MEM_rq=1, RnW=1, Y_sel=0, M=00, Acc_En=1.
  - 1 STA: MEM_rq=1, RnW=0, all enables 0.
  - 2 ADD: MEM_rq=1, RnW=1, X_sel=0, Y_sel=0, M=01, Acc_En=1.
  - 3 SUB: as ADD, but M=11.
  - 4 JMP: Y_sel=1, M=00, PC_En=1, MEM_rq=0.
  - 5 JGE: as JMP, but PC_En = ~N.
  - 6 JNE: as JMP, but PC_En = ~Z.
  - 7 STP: all enables 0, MEM_rq=0. Next state is HALT.
  - 8–F: NOP; all enables 0, MEM_rq=0.
  - Next state is FETCH, except for STP.
- **HALT:** Halted=1, all enables 0, MEM_rq=0, RnW=1. Remains in HALT until Reset.
- Defaults when not driven by the rules above: RnW=1, selects 0, M=00.
- **Reset:** Reset=0 at a rising edge loads FETCH. While Reset=0, PC_En, IR_En, Acc_En and MEM_rq are forced to 0 and Halted=0.
- **Reset values:** after release, outputs show FETCH values. All enables are 0 and Halted=0 while Reset is held low.

## Timing
- A non-memory instruction takes 2 cycles (FETCH + EXECUTE) with zero wait states.
- N and Z are sampled combinationally in the EXECUTE cycle. They reflect the accumulator as committed at the preceding edge.
- Reset mid-instruction (during EXECUTE or HALT) goes to FETCH on the same edge. The in-flight enables are suppressed in that cycle.
- Flag inputs are ignored in FETCH and HALT.

## Configuration
- **MU0_WAIT_EN defined:** in any state with MEM_rq=1, the state holds while Ready=0.
  - While stalled, PC_En, IR_En and Acc_En are forced to 0. MEM_rq, RnW, Addr_sel and the selects remain stable.
  - The enables assert, and the state advances, only in the cycle where Ready=1.
  - Non-memory EXECUTE cycles (JMP/JGE/JNE/STP/NOP) ignore Ready.
- **MU0_WAIT_EN undefined:** Ready is unused and every state lasts exactly 1 cycle.

## Test plan
- **Reset:** hold Reset=0 for 2 edges, then release → Halted=0, enables 0 while low. The first cycle after release shows FETCH outputs (PC_En=1, IR_En=1, M=10, MEM_rq=1, RnW=1).
- **Opcode sweep:** F=0,2,3 each followed by FETCH → correct M (00/01/11), Acc_En=1, Addr_sel=1 in EXECUTE. F=1 → RnW=0, Acc_En=0.
- **Conditional jumps:**
  - F=5 with N=1 → PC_En=0; with N=0 → PC_En=1, Y_sel=1, M=00.
  - F=6 with Z=1 → PC_En=0; with Z=0 → PC_En=1.
- **Halt:** F=7 → Halted=1 from the next cycle, enables 0 for 10 cycles. Then Reset=0 for 1 edge → FETCH, Halted=0.
- **Mid-instruction reset and NOP:** Reset=0 during EXECUTE of F=2 → Acc_En=0 in that cycle, FETCH next. F=4'hC → all enables 0, returns to FETCH.
- **Wait states (MU0_WAIT_EN):** Ready=0 for 3 cycles in FETCH → state held, IR_En/PC_En=0, MEM_rq=1. Ready=1 → enables assert once, then EXECUTE. Same check for LDA in EXECUTE.
